// File: rtl/uop_queue_pkg.sv
// Shared types and sizing for the decoder-to-issue micro-op queue.
package uop_queue_pkg;

    localparam int IN_UOP  = 5;   // max uops accepted per cycle
    localparam int OUT_UOP = 1;   // uops presented per cycle (only 1 supported)
    localparam int QU_UOP  = 16;  // queue depth, power of two
    localparam int IDX_W   = $clog2(QU_UOP);

    // Ring pointer; wraps modulo QU_UOP by its width alone.
    typedef logic [IDX_W-1:0] uop_index_t;
    // Occupancy, one bit wider than the pointer so that "full" is representable.
    typedef logic [IDX_W:0]   uop_count_t;
    // Group size presented by the decoder.
    typedef logic [2:0]       uop_grp_cnt_t;

    typedef struct packed {
        logic [7:0]  color;
        logic [7:0]  opcode;
        logic [15:0] imm;
    } uop_ins_t;

endpackage

// File: rtl/uop_queue_if.sv
// Decoder-side group enqueue, issue-side single dequeue, flush and occupancy.
interface uop_queue_if;
    import uop_queue_pkg::*;

    logic                      flush;
    logic                      in_valid;
    uop_grp_cnt_t              in_count;
    uop_ins_t [IN_UOP-1:0]     in_uops;
    logic                      in_ready;
    logic                      out_valid;
    uop_ins_t                  out_uop;
    logic                      out_ready;
    uop_count_t                occupancy;

    // Side that feeds groups and consumes uops.
    modport master (
        output flush, in_valid, in_count, in_uops, out_ready,
        input  in_ready, out_valid, out_uop, occupancy
    );

    // The queue itself.
    modport slave (
        input  flush, in_valid, in_count, in_uops, out_ready,
        output in_ready, out_valid, out_uop, occupancy
    );

endinterface

// File: rtl/uop_queue.sv
// Circular micro-op buffer: all-or-nothing group enqueue, one uop out per cycle.
module uop_queue
    import uop_queue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    uop_queue_if.slave  q
);

    uop_index_t head_q, head_d;
    uop_index_t tail_q, tail_d;
    uop_count_t count_q, count_d;
    uop_ins_t   mem_q [QU_UOP];

    uop_count_t            free;
    logic                  enq;
    logic                  deq;
    logic [IN_UOP-1:0]     wr_en;
    uop_index_t            wr_idx [IN_UOP];

    // Handshake decode; depends only on registered state and the presented group.
    always_comb begin
        free        = uop_count_t'(QU_UOP) - count_q;
        q.in_ready  = (q.in_count <= uop_grp_cnt_t'(IN_UOP)) &&
                      (free >= uop_count_t'(q.in_count));
        enq         = q.in_valid && q.in_ready && !q.flush;
        q.out_valid = (count_q != '0);
        deq         = q.out_valid && q.out_ready && !q.flush;
        // Empty queue presents zero rather than whatever stale entry head points at.
        q.out_uop   = q.out_valid ? mem_q[head_q] : '0;
        q.occupancy = count_q;
    end

    // Pointer and occupancy update; flush wins over any concurrent enqueue/dequeue.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + uop_index_t'(q.in_count);
            if (deq) head_d = head_q + 1'b1;
            count_d = count_q
                    + (enq ? uop_count_t'(q.in_count) : '0)
                    - (deq ? uop_count_t'(1) : '0);
        end
    end

    // Per-slot write ports: slot i lands at tail+i, wrapping through index 0.
    always_comb begin
        for (int i = 0; i < IN_UOP; i++) begin
            wr_en[i]  = enq && (i < int'(q.in_count));
            wr_idx[i] = tail_q + uop_index_t'(i);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage with IN_UOP write ports.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; out_uop is gated to zero while empty instead.
        for (int i = 0; i < IN_UOP; i++) begin
            if (wr_en[i]) mem_q[wr_idx[i]] <= q.in_uops[i];
        end
    end

endmodule

// File: tb/tb_uop_queue.sv
// Self-checking bench for uop_queue: queue-based reference model plus directed scenarios.
module tb_uop_queue;
    import uop_queue_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uop_queue_if qif();

    uop_queue dut (
        .clk   (clk),
        .reset (reset),
        .q     (qif.slave)
    );

    always #5 clk = ~clk;

    int tests      = 0;
    int fails      = 0;
    int next_color = 0;

    // Reference model: an ordered list of held uops and the ring write position.
    uop_ins_t mq[$];
    int       m_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic uop_ins_t make_uop(input int c);
        uop_ins_t u;
        u.color  = 8'(c);
        u.opcode = 8'(c * 3 + 1);
        u.imm    = 16'(c * 17 + 5);
        return u;
    endfunction

    // A group fits when it is legal in size and there is room for all of it.
    function automatic bit m_ready();
        return (int'(qif.in_count) <= IN_UOP) && ((QU_UOP - mq.size()) >= int'(qif.in_count));
    endfunction

    // Model update on each clock edge; asynchronous reset empties it at once.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_tail = 0;
        end else begin
            bit do_enq;
            bit do_deq;
            do_enq = qif.in_valid && m_ready() && !qif.flush;
            do_deq = (mq.size() != 0) && qif.out_ready && !qif.flush;
            if (qif.flush) begin
                mq.delete();
                m_tail = 0;
            end else begin
                if (do_deq) void'(mq.pop_front());
                if (do_enq) begin
                    for (int i = 0; i < int'(qif.in_count); i++) mq.push_back(qif.in_uops[i]);
                    m_tail = (m_tail + int'(qif.in_count)) % QU_UOP;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("occupancy", 32'(qif.occupancy), 32'(mq.size()));
        check("out_valid", 32'(qif.out_valid), 32'(mq.size() != 0));
        check("in_ready",  32'(qif.in_ready),  32'(m_ready()));
        if (mq.size() != 0) check("out_uop", 32'(qif.out_uop), 32'(mq[0]));
        if (int'(qif.in_count) > IN_UOP) begin
            a_illegal_count: assert (!qif.in_ready)
                else $error("illegal in_count %0d accepted", qif.in_count);
        end
    end

    task automatic idle();
        qif.in_valid  = 1'b0;
        qif.in_count  = '0;
        qif.out_ready = 1'b0;
        qif.flush     = 1'b0;
        for (int i = 0; i < IN_UOP; i++) qif.in_uops[i] = '0;
    endtask

    // Present a group with fresh colors; unused slots carry junk that must be ignored.
    task automatic setup(input bit v, input int cnt, input bit ordy, input bit fl);
        uop_ins_t junk;
        junk.color  = 8'hEE;
        junk.opcode = 8'hFF;
        junk.imm    = 16'hDEAD;
        qif.in_valid  = v;
        qif.in_count  = 3'(cnt);
        qif.out_ready = ordy;
        qif.flush     = fl;
        for (int i = 0; i < IN_UOP; i++) begin
            if (i < cnt) qif.in_uops[i] = make_uop(next_color + i);
            else         qif.in_uops[i] = junk;
        end
        next_color += cnt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic go(input bit v, input int cnt, input bit ordy, input bit fl);
        setup(v, cnt, ordy, fl);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        check("rst out_valid", 32'(qif.out_valid), 0);
        check("rst occupancy", 32'(qif.occupancy), 0);
        check("rst in_ready",  32'(qif.in_ready),  1);
        check("rst out_uop",   32'(qif.out_uop),   0);

        // Five uops in, drained in order.
        go(1, 5, 0, 0);
        check("t1 out_valid", 32'(qif.out_valid), 1);
        check("t1 occupancy", 32'(qif.occupancy), 5);
        for (int k = 0; k < 5; k++) begin
            check("t1 color", 32'(qif.out_uop.color), 32'(k));
            go(0, 0, 1, 0);
        end
        check("t1 drained valid", 32'(qif.out_valid), 0);
        check("t1 drained occ",   32'(qif.occupancy), 0);

        // out_ready while empty and an empty group are both no-ops.
        go(0, 0, 1, 0);
        check("empty deq occ", 32'(qif.occupancy), 0);
        go(1, 0, 0, 0);
        check("zero group occ", 32'(qif.occupancy), 0);

        // Fill to 15, reject a group of 2, accept 1, then full.
        repeat (3) go(1, 5, 0, 0);
        check("fill15 occ", 32'(qif.occupancy), 15);
        setup(1, 2, 0, 0);
        #1;
        check("fill15 ready2", 32'(qif.in_ready), 0);
        step();
        check("fill15 reject occ", 32'(qif.occupancy), 15);
        setup(1, 1, 0, 0);
        #1;
        check("fill15 ready1", 32'(qif.in_ready), 1);
        step();
        check("full occ", 32'(qif.occupancy), 16);
        for (int c = 1; c <= 5; c++) begin
            setup(1, c, 0, 0);
            #1;
            check("full ready", 32'(qif.in_ready), 0);
            idle();
        end

        // Full with a same-cycle dequeue gives no enqueue credit.
        setup(1, 1, 1, 0);
        #1;
        check("full simul ready", 32'(qif.in_ready), 0);
        step();
        check("full simul occ", 32'(qif.occupancy), 15);
        go(1, 1, 1, 0);
        check("enq+deq occ", 32'(qif.occupancy), 15);
        repeat (15) go(0, 0, 1, 0);
        check("drain occ", 32'(qif.occupancy), 0);

        // Illegal group sizes are refused and write nothing.
        for (int c = 6; c <= 7; c++) begin
            setup(1, c, 0, 0);
            #1;
            check("illegal ready", 32'(qif.in_ready), 0);
            step();
            check("illegal occ", 32'(qif.occupancy), 0);
        end

        // Wrap: walk the ring to index 14, then enqueue a straddling group.
        for (int k = 0; k < 16 && m_tail != 14; k++) go(1, 1, 1, 0);
        go(0, 0, 1, 0);
        check("wrap pre occ", 32'(qif.occupancy), 0);
        base = next_color;
        go(1, 5, 0, 0);
        check("wrap model tail", 32'(m_tail), 3);
        check("wrap occ", 32'(qif.occupancy), 5);
        for (int k = 0; k < 5; k++) begin
            check("wrap color", 32'(qif.out_uop.color), 32'(base + k));
            go(0, 0, 1, 0);
        end
        check("wrap drained", 32'(qif.out_valid), 0);

        // Flush at count 7 drops the concurrent group and the held entries.
        go(1, 5, 0, 0);
        go(1, 2, 0, 0);
        check("pre flush occ", 32'(qif.occupancy), 7);
        base = next_color;
        go(1, 3, 1, 1);
        check("flush occ",   32'(qif.occupancy), 0);
        check("flush valid", 32'(qif.out_valid), 0);
        go(1, 1, 0, 0);
        check("post flush color", 32'(qif.out_uop.color), 32'(base + 3));
        go(0, 0, 1, 0);

        // Asynchronous reset mid-cycle at count 9.
        go(1, 5, 0, 0);
        go(1, 4, 0, 0);
        check("pre reset occ", 32'(qif.occupancy), 9);
        #2;
        reset = 1'b1;
        #1;
        check("async rst occ",   32'(qif.occupancy), 0);
        check("async rst valid", 32'(qif.out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("post rst ready", 32'(qif.in_ready),  1);
        check("post rst valid", 32'(qif.out_valid), 0);
        go(0, 0, 1, 0);
        check("post rst idle occ", 32'(qif.occupancy), 0);
        base = next_color;
        go(1, 2, 0, 0);
        check("post rst color", 32'(qif.out_uop.color), 32'(base));
        check("post rst occ",   32'(qif.occupancy), 2);
        go(0, 0, 1, 0);
        go(0, 0, 1, 0);
        check("final occ", 32'(qif.occupancy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
